// File: rtl/spi_conf_rx_pkg.sv
// Shared definitions for the ARM->FPGA SPI configuration receiver.
//   CMD_SET_CONFREG : command nibble that carries a new configuration word
//   CONF_RESET      : configuration after reset (major mode OFF, all else off)
//   MM_*            : major-mode encodings found in conf_word[7:5]
//   state_t         : receiver FSM states
package spi_conf_pkg;

  localparam logic [3:0] CMD_SET_CONFREG = 4'b0001;
  localparam logic [7:0] CONF_RESET      = 8'hE0;

  localparam logic [2:0] MM_READ_TX       = 3'd0;
  localparam logic [2:0] MM_READ_RX_XCORR = 3'd1;
  localparam logic [2:0] MM_SIMULATE      = 3'd2;
  localparam logic [2:0] MM_ISO14443A     = 3'd3;
  localparam logic [2:0] MM_SNIFFER       = 3'd4;
  localparam logic [2:0] MM_OFF           = 3'd7;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, PEND} state_t;

endpackage

// File: rtl/spi_conf_rx_if.sv
// Bus bundle between the ARM SPI master / carrier timing logic and the
// configuration receiver.
//   spck, mosi, ncs : SPI from the ARM (asynchronous to pck0)
//   apply_en        : mode-safe apply strobe
//   conf_word       : active configuration word
//   major_mode      : conf_word[7:5]
//   conf_valid      : one-cycle pulse when conf_word updates
//   cmd_err         : one-cycle pulse on a malformed frame
//   miso            : readback data (only with SPI_CONF_READBACK_EN defined)
interface spi_conf_rx_if #(
  parameter int CONF_W = 8
);
  logic              spck;
  logic              mosi;
  logic              ncs;
  logic              apply_en;
  logic [CONF_W-1:0] conf_word;
  logic [2:0]        major_mode;
  logic              conf_valid;
  logic              cmd_err;
`ifdef SPI_CONF_READBACK_EN
  logic              miso;

  modport master (output spck, mosi, ncs, apply_en,
                  input  conf_word, major_mode, conf_valid, cmd_err, miso);
  modport slave  (input  spck, mosi, ncs, apply_en,
                  output conf_word, major_mode, conf_valid, cmd_err, miso);
`else
  modport master (output spck, mosi, ncs, apply_en,
                  input  conf_word, major_mode, conf_valid, cmd_err);
  modport slave  (input  spck, mosi, ncs, apply_en,
                  output conf_word, major_mode, conf_valid, cmd_err);
`endif
endinterface

// File: rtl/spi_conf_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus edge detection.
// The edges compare the last synchronizer stage against one extra registered
// copy, so rise/fall are single-cycle pulses in the pck0 domain.
//   pck0, rst : clock, asynchronous active-high reset
//   din       : asynchronous input
//   dout      : synchronized level
//   rise/fall : one-cycle edge pulses
// RST_VAL sets the idle level so that reset release produces no edge.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic pck0,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      last_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & last_q;

endmodule

// File: rtl/spi_conf_rx.sv
// Fully synchronous SPI configuration receiver, clocked only by pck0.
// Oversamples spck/mosi/ncs, assembles WORD_W-bit frames and decodes
// CMD_SET_CONFREG. A decoded word is held pending until apply_en so the
// active configuration never changes mid carrier cycle.
//   pck0, rst : clock, asynchronous active-high reset
//   bus       : spi_conf_rx_if.slave (SPI inputs, apply_en, conf outputs)
// Optional build macro SPI_CONF_READBACK_EN adds bus.miso: on each frame
// start a readback register loads {CMD_SET_CONFREG, 0000, conf_word} and
// shifts out MSB-first on every spck falling edge.
module spi_conf_rx
  import spi_conf_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int CONF_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic          pck0,
  input logic          rst,
  spi_conf_rx_if.slave bus
);

  localparam logic [4:0] CNT_FULL = 5'(WORD_W);
  localparam logic [4:0] CNT_MAX  = 5'(WORD_W + 1);

  logic spck_s, spck_rise, spck_fall;
  logic ncs_s, ncs_rise, ncs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_spck (
    .pck0(pck0), .rst(rst), .din(bus.spck),
    .dout(spck_s), .rise(spck_rise), .fall(spck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .pck0(pck0), .rst(rst), .din(bus.ncs),
    .dout(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .pck0(pck0), .rst(rst), .din(bus.mosi),
    .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  state_t            state;
  logic [WORD_W-1:0] shift_reg;
  logic [4:0]        bit_cnt;
  logic              pending;
  logic [CONF_W-1:0] pending_word;
  logic              nf_hold;
  logic [CONF_W-1:0] conf_word;
  logic              conf_valid;
  logic              cmd_err;

  // A frame start seen while busy is remembered until IDLE/PEND takes it.
  logic frame_start;
  logic apply_now;
  logic keep_pend;

  assign frame_start = ncs_fall | nf_hold;
  assign apply_now   = pending & bus.apply_en;
  // Pending survives this cycle only if it is not being applied right now.
  assign keep_pend   = pending & ~bus.apply_en;

  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      pending      <= 1'b0;
      pending_word <= '0;
      nf_hold      <= 1'b0;
      conf_word    <= CONF_W'(CONF_RESET);
      conf_valid   <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      conf_valid <= 1'b0;
      cmd_err    <= 1'b0;
      nf_hold    <= frame_start & (state != IDLE) & (state != PEND);

      // Apply is independent of the FSM state; a load in CHECK below
      // overrides the pending clear so a new word is never lost.
      if (apply_now) begin
        conf_word  <= pending_word;
        pending    <= 1'b0;
        conf_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (spck_rise) begin
            shift_reg <= {shift_reg[WORD_W-2:0], mosi_s};
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 5'd1;
          end
          if (ncs_rise) state <= CHECK;
        end
        CHECK: begin
          if (bit_cnt != CNT_FULL) begin
            cmd_err <= 1'b1;
            state   <= keep_pend ? PEND : IDLE;
          end else if (shift_reg[WORD_W-1 -: 4] == CMD_SET_CONFREG) begin
            pending_word <= shift_reg[CONF_W-1:0];
            pending      <= 1'b1;
            state        <= PEND;
          end else begin
            state <= keep_pend ? PEND : IDLE;
          end
        end
        PEND: begin
          if (frame_start) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end else if (!pending || bus.apply_en) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.conf_word  = conf_word;
  assign bus.major_mode = conf_word[CONF_W-1 -: 3];
  assign bus.conf_valid = conf_valid;
  assign bus.cmd_err    = cmd_err;

`ifdef SPI_CONF_READBACK_EN
  logic [WORD_W-1:0] rb_reg;

  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      rb_reg <= '0;
    end else if (ncs_fall) begin
      rb_reg <= {CMD_SET_CONFREG, {(WORD_W-4-CONF_W){1'b0}}, conf_word};
    end else if (spck_fall) begin
      rb_reg <= {rb_reg[WORD_W-2:0], 1'b0};
    end
  end

  assign bus.miso = rb_reg[WORD_W-1] & ~ncs_s;

  logic unused_sig;
  assign unused_sig = &{1'b0, spck_s, mosi_rise, mosi_fall};
`else
  logic unused_sig;
  assign unused_sig = &{1'b0, spck_s, spck_fall, ncs_s, mosi_rise, mosi_fall};
`endif

endmodule

// File: tb/tb_spi_conf_rx.sv
// Self-checking bench for spi_conf_rx. A frame-level model predicts
// conf_word/major_mode/conf_valid/cmd_err for every cycle; directed tests
// pin the model with literal values, then randomized frames and apply_en.
module tb_spi_conf_rx;

  logic pck0 = 1'b0;
  logic rst  = 1'b1;
  logic spck = 1'b0;
  logic mosi = 1'b0;
  logic ncs  = 1'b1;
  logic apply_en = 1'b1;
  logic rand_apply = 1'b0;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int valid_seen = 0;
  int err_seen   = 0;

  typedef struct {
    int          load_edge;
    int          nbits;
    logic [15:0] data;
  } fr_t;

  fr_t q[$];

  spi_conf_rx_if #(.CONF_W(8)) bus ();

  assign bus.spck     = spck;
  assign bus.mosi     = mosi;
  assign bus.ncs      = ncs;
  assign bus.apply_en = apply_en;

  spi_conf_rx dut (.pck0(pck0), .rst(rst), .bus(bus.slave));

  always #5 pck0 = ~pck0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: a frame decides its outcome three edges after the first
  // edge that sees ncs high; a pending word is applied on any later edge
  // where apply_en is sampled high. Newest decoded word replaces older ones.
  logic [7:0] m_conf = 8'hE0;
  logic [7:0] m_pword = 8'h00;
  logic       m_pend = 1'b0;
  logic       exp_valid = 1'b0;
  logic       exp_err = 1'b0;

  initial begin
    fr_t r;
    forever begin
      @(posedge pck0);
      edge_n++;
      if (rst) begin
        m_conf = 8'hE0; m_pend = 1'b0; exp_valid = 1'b0; exp_err = 1'b0;
        q.delete();
      end else begin
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (m_pend && apply_en) begin
          m_conf = m_pword; m_pend = 1'b0; exp_valid = 1'b1;
        end
        while (q.size() > 0 && q[0].load_edge <= edge_n) begin
          r = q.pop_front();
          if (r.nbits != 16) exp_err = 1'b1;
          else if (r.data[15:12] == 4'h1) begin
            m_pend = 1'b1; m_pword = r.data[7:0];
          end
        end
      end
      @(negedge pck0);
      if (!rst) begin
        chk("conf_word", 32'(bus.conf_word), 32'(m_conf));
        chk("major_mode", 32'(bus.major_mode), 32'(m_conf[7:5]));
        chk("conf_valid", 32'(bus.conf_valid), 32'(exp_valid));
        chk("cmd_err", 32'(bus.cmd_err), 32'(exp_err));
        if (bus.conf_valid) valid_seen++;
        if (bus.cmd_err) err_seen++;
      end
    end
  end

  task automatic tick();
    @(negedge pck0);
    if (rand_apply) apply_en = ($urandom_range(0, 3) == 0);
  endtask

  // Sends bits w[nbits-1:0] MSB-first; returns at the negedge where ncs was
  // raised, with e1 = first edge that samples ncs high.
  task automatic send_frame(input int nbits, input logic [23:0] w, input int h,
                            output int e1, output logic [15:0] rb);
    rb = '0;
    ncs = 1'b0;
    repeat (3) tick();
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = w[i];
      repeat (h) tick();
`ifdef SPI_CONF_READBACK_EN
      if (nbits - 1 - i < 16) rb = {rb[14:0], bus.miso};
`endif
      spck = 1'b1;
      repeat (h) tick();
      spck = 1'b0;
    end
    repeat (3) tick();
    ncs = 1'b1;
    e1 = edge_n + 1;
    q.push_back('{e1 + 3, nbits, w[15:0]});
  endtask

  task automatic frame(input int nbits, input logic [23:0] w, input int h);
    int e1;
    logic [15:0] rb;
    send_frame(nbits, w, h, e1, rb);
    repeat (6) tick();
  endtask

  initial begin
    int e1, v0, r0, nb, h;
    logic [15:0] rb;
    logic [23:0] w;

    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("reset conf_word", 32'(bus.conf_word), 32'h00E0);
    chk("reset major_mode", 32'(bus.major_mode), 32'h7);
    chk("reset conf_valid", 32'(bus.conf_valid), 32'h0);
    chk("reset cmd_err", 32'(bus.cmd_err), 32'h0);

    // Immediate apply: update exactly at E5
    apply_en = 1'b1;
    send_frame(16, 24'h001023, 4, e1, rb);
    while (edge_n < e1 + 3) tick();
    chk("E4 conf_valid", 32'(bus.conf_valid), 32'h0);
    chk("E4 conf_word", 32'(bus.conf_word), 32'h00E0);
    tick();
    chk("E5 conf_valid", 32'(bus.conf_valid), 32'h1);
    chk("E5 conf_word", 32'(bus.conf_word), 32'h0023);
    chk("E5 major_mode", 32'(bus.major_mode), 32'h1);
    tick();
    chk("E6 conf_valid", 32'(bus.conf_valid), 32'h0);
    repeat (6) tick();

    // Deferred apply
    apply_en = 1'b0;
    frame(16, 24'h001061, 4);
    repeat (50) tick();
    chk("held conf_word", 32'(bus.conf_word), 32'h0023);
    apply_en = 1'b1;
    tick();
    chk("deferred conf_word", 32'(bus.conf_word), 32'h0061);
    chk("deferred conf_valid", 32'(bus.conf_valid), 32'h1);
    repeat (4) tick();

    // Short and long frames
    v0 = valid_seen; r0 = err_seen;
    frame(15, 24'h001023, 3);
    frame(17, 24'h001023, 3);
    repeat (4) tick();
    chk("bad length err count", 32'(err_seen - r0), 32'd2);
    chk("bad length valid count", 32'(valid_seen - v0), 32'd0);
    chk("bad length conf_word", 32'(bus.conf_word), 32'h0061);

    // Unknown command, then last-wins pending
    v0 = valid_seen; r0 = err_seen;
    frame(16, 24'h002055, 2);
    repeat (4) tick();
    chk("unknown cmd err count", 32'(err_seen - r0), 32'd0);
    chk("unknown cmd valid count", 32'(valid_seen - v0), 32'd0);
    apply_en = 1'b0;
    frame(16, 24'h001040, 2);
    frame(16, 24'h001080, 2);
    repeat (5) tick();
    chk("pending conf_word", 32'(bus.conf_word), 32'h0061);
    apply_en = 1'b1;
    repeat (3) tick();
    chk("last wins conf_word", 32'(bus.conf_word), 32'h0080);
    chk("last wins valid count", 32'(valid_seen - v0), 32'd1);

    // Reset in the middle of a frame
    ncs = 1'b0;
    repeat (3) tick();
    w = 24'h0010A5;
    for (int i = 15; i >= 7; i--) begin
      mosi = w[i];
      repeat (3) tick();
      spck = 1'b1;
      repeat (3) tick();
      spck = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("mid-frame reset conf_word", 32'(bus.conf_word), 32'h00E0);
    chk("mid-frame reset major_mode", 32'(bus.major_mode), 32'h7);
    ncs = 1'b1;
    mosi = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    frame(16, 24'h0010A5, 3);
    chk("after reset conf_word", 32'(bus.conf_word), 32'h00A5);
    send_frame(16, 24'h002000, 4, e1, rb);
`ifdef SPI_CONF_READBACK_EN
    chk("readback miso", 32'(rb), 32'h10A5);
`endif
    repeat (6) tick();

    // Randomized frames with random apply strobes
    rand_apply = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int pick;
      pick = $urandom_range(0, 9);
      nb = (pick == 0) ? 15 : (pick == 1) ? 17 : (pick == 2) ? 20 : 16;
      h  = $urandom_range(2, 5);
      w  = 24'($urandom);
      if ($urandom_range(0, 3) != 0) w[15:12] = 4'h1;
      frame(nb, w, h);
      repeat ($urandom_range(0, 8)) tick();
    end
    rand_apply = 1'b0;
    apply_en = 1'b1;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
